wisard_addr_gen: RTL
====================

Name: wisard_addr_gen

Overview:
- Producer end of the WiSARD address stream that feeds the LUT RAM bank and the classification controller.
- Accepts one pre-mapped input pattern per handshake and holds it.
- Serialises the pattern into one address per LUT, one address per cycle, framed with sop/eop/source_valid.
- Enforces a programmable idle gap after each frame so the downstream highest-score search completes before the next sop.

Parameters:
- ADDRESS_WIDTH, 14, bits per LUT address (slice width).
- INDEX_WIDTH, 5, width of LUT index output; N_LUTS <= 2**INDEX_WIDTH required.
- N_LUTS, 28, number of LUTs (address slices) per pattern; >= 1.
- GAP_CYCLES, 4, idle cycles forced after eop before sink_ready reasserts; 0 allowed. The system setting is >= N_CLASSES+3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sink_valid  in  1  input pattern valid.
- sink_ready  out  1  block can accept a pattern.
- sink_data  in  N_LUTS*ADDRESS_WIDTH  mapped pattern; slice k = sink_data[k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- source_valid  out  1  address/index valid this cycle.
- sop  out  1  first address of frame (index 0).
- eop  out  1  last address of frame (index N_LUTS-1).
- address  out  ADDRESS_WIDTH  current LUT address.
- index  out  INDEX_WIDTH  current LUT number.

Behaviour:
- Clock and reset: one clock domain (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, sink_ready=1, source_valid=0, sop=0, eop=0, address=0, index=0, internal pattern register=0, gap counter=0.
- Reset asserted mid-frame or mid-gap aborts immediately, with no further output beats.
- State machine: IDLE, SEND, GAP.
- sink_ready = (state==IDLE), decoded from the state register.
- IDLE:
  - Transfer occurs when sink_valid && sink_ready.
  - On transfer, latch sink_data into the pattern register and go to SEND.
  - sink_valid while not ready is ignored; the source must hold its data.
- SEND:
  - All outputs are registered. First beat appears the cycle after the transfer cycle (latency 1).
  - Beat k (k=0..N_LUTS-1): source_valid=1, index=k, address=slice k, sop=(k==0), eop=(k==N_LUTS-1).
  - Beats are contiguous, with no stalls and no output backpressure.
  - N_LUTS==1: single beat with sop=eop=1.
  - After the eop beat: go to GAP with counter=GAP_CYCLES, or to IDLE if GAP_CYCLES==0.
- GAP:
  - source_valid, sop, eop = 0.
  - Counter decrements each cycle; go to IDLE when it reaches 1.
  - sink_ready=0 throughout.
- Outside beats:
  - source_valid, sop and eop are 0.
  - address and index hold their last value; downstream qualifies them with source_valid only.
- Throughput: one pattern per N_LUTS+GAP_CYCLES+1 cycles. The transfer cycle is not overlapped with the last beat.
- Index counter: width INDEX_WIDTH, never exceeds N_LUTS-1, cleared on entry to SEND.
- Slice selection: index-based mux or shift register; either is acceptable if the output is cycle-identical.

Test Plan:
(Bench parameters: ADDRESS_WIDTH=4, INDEX_WIDTH=2, N_LUTS=3, GAP_CYCLES=2.)
1. Reset release, idle: no stimulus -> sink_ready=1, source_valid=0, sop=eop=0, address=0, index=0.
2. Single frame: sink_valid=1, sink_data=12'hCBA at cycle T -> T+1: address=A, index 0, sop=1; T+2: address=B, index 1; T+3: address=C, index 2, eop=1; sink_ready=0 from T+1 through T+5, and 1 at T+6.
3. Back-to-back: sink_valid held high with 12'h321 then 12'h654 -> second transfer at T+6; beats 1,2,3 then 4,5,6; sop-to-sop spacing exactly 6 cycles; data presented while not ready is never sampled.
4. Boundary N_LUTS=1, GAP_CYCLES=0, data 4'h9 -> one beat: address=9, sop=eop=1, source_valid=1; sink_ready back at 1 in the following cycle; period 2 cycles.
5. Reset mid-frame: assert rst_n=0 during beat index 1 -> outputs go to reset values asynchronously, with no eop. After release, a new 12'hFED frame starts at sop with address=D.
6. Downstream integration: chain with the classification controller (N_CLASSES=2), GAP_CYCLES=5, two frames -> exactly two source_valid pulses from the controller, each carrying the expected class.

Source files
------------

// File: rtl/wisard_addr_gen_if.sv
// Handshake/stream bundle for the WiSARD address generator: pattern sink plus
// framed address/index source. The master side is the address generator itself.
interface wisard_addr_gen_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int INDEX_WIDTH   = 5,
  parameter int N_LUTS        = 28
);
  logic                              sink_valid;
  logic                              sink_ready;
  logic [N_LUTS*ADDRESS_WIDTH-1:0]   sink_data;
  logic                              source_valid;
  logic                              sop;
  logic                              eop;
  logic [ADDRESS_WIDTH-1:0]          address;
  logic [INDEX_WIDTH-1:0]            index;

  modport master (
    input  sink_valid,
    input  sink_data,
    output sink_ready,
    output source_valid,
    output sop,
    output eop,
    output address,
    output index
  );

  modport slave (
    output sink_valid,
    output sink_data,
    input  sink_ready,
    input  source_valid,
    input  sop,
    input  eop,
    input  address,
    input  index
  );
endinterface

// File: rtl/wisard_addr_gen.sv
// WiSARD address generator: latches one mapped pattern, streams one LUT address
// per cycle framed by sop/eop, then holds off new patterns for GAP_CYCLES.
module wisard_addr_gen #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int INDEX_WIDTH   = 5,
  parameter int N_LUTS        = 28,
  parameter int GAP_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wisard_addr_gen_if.master bus
);

  localparam int PW = N_LUTS * ADDRESS_WIDTH;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(N_LUTS - 1);
  localparam logic [GW-1:0]          GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                   state_q;
  logic [PW-1:0]            pattern_q;
  logic [GW-1:0]            gap_q;
  logic [INDEX_WIDTH-1:0]   index_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic                     valid_q;
  logic                     sop_q;
  logic                     eop_q;
  logic [INDEX_WIDTH-1:0]   index_inc_d;

  function automatic logic [ADDRESS_WIDTH-1:0] slice_at(
    input logic [PW-1:0]          pat,
    input logic [INDEX_WIDTH-1:0] k
  );
    return pat[k * ADDRESS_WIDTH +: ADDRESS_WIDTH];
  endfunction

  assign index_inc_d = index_q + 1'b1;

  assign bus.sink_ready   = (state_q == IDLE);
  assign bus.source_valid = valid_q;
  assign bus.sop          = sop_q;
  assign bus.eop          = eop_q;
  assign bus.address      = address_q;
  assign bus.index        = index_q;

  // Frame FSM: beat k is registered one edge ahead of its cycle, so beat 0
  // leaves on the transfer edge and each later beat is prepared from index_q+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      gap_q     <= '0;
      index_q   <= '0;
      address_q <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sink_valid) begin
            pattern_q <= bus.sink_data;
            index_q   <= '0;
            address_q <= bus.sink_data[ADDRESS_WIDTH-1:0];
            valid_q   <= 1'b1;
            sop_q     <= 1'b1;
            eop_q     <= (LAST_IDX == '0);
            state_q   <= SEND;
          end
        end
        SEND: begin
          sop_q <= 1'b0;
          if (index_q == LAST_IDX) begin
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              gap_q   <= GAP_LOAD;
              state_q <= GAP;
            end
          end else begin
            index_q   <= index_inc_d;
            address_q <= slice_at(pattern_q, index_inc_d);
            eop_q     <= (index_inc_d == LAST_IDX);
          end
        end
        GAP: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q == GW'(1)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          sop_q   <= 1'b0;
          eop_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
